eth_rx_dst_mac_filter: RTL and testbench
========================================

// Module: eth_rx_dst_mac_filter
// PURPOSE
//  Sits in the logic_clk domain directly downstream of the 1G RGMII MAC's RX FIFO output (8-bit AXIS, frame-FIFO mode).
//  Buffers each frame's 6-byte destination MAC and compares it against the configured station address, broadcast and multicast rules.
//  Replays accepted frames unchanged to the consumer and silently drains rejected or runt frames.
//  Maintains saturating accept/drop counters.
// PARAMETERS
//  CNT_WIDTH  32  width of accepted_cnt_o / dropped_cnt_o / runt_cnt_o
// PORTS
//  logic_clk       in   1   sole clock
//  logic_rst_n     in   1   reset; synchronous, active-low
//  s_axis_tdata    in   8   RX byte from MAC FIFO
//  s_axis_tvalid   in   1   upstream valid
//  s_axis_tready   out  1   upstream ready
//  s_axis_tlast    in   1   last byte of frame
//  s_axis_tuser    in   1   bad-frame flag, meaningful on tlast only
//  m_axis_tdata    out  8   filtered byte to consumer
//  m_axis_tvalid   out  1   downstream valid
//  m_axis_tready   in   1   downstream ready
//  m_axis_tlast    out  1   last byte of frame
//  m_axis_tuser    out  1   passed through from s_axis_tuser
//  mac_addr_i      in   48  station address; [47:40] is the first byte on the wire
//  promisc_i       in   1   accept every frame of >= 6 bytes
//  bcast_en_i      in   1   accept FF:FF:FF:FF:FF:FF
//  mcast_en_i      in   1   accept when I/G bit (LSB of first byte) = 1
//  accepted_cnt_o  out  CNT_WIDTH  frames forwarded
//  dropped_cnt_o   out  CNT_WIDTH  frames rejected by address
//  runt_cnt_o      out  CNT_WIDTH  frames shorter than 6 bytes
// BEHAVIOUR
//  - Reset (logic_rst_n=0 at a logic_clk edge): state=HDR, byte idx=0, all counters=0, m_axis_tvalid=0, s_axis_tready=0 during reset.
//    Reset mid-frame abandons the frame; bytes from the rest of that frame are treated as a new frame.
//  - Handshake: a transfer occurs when valid&ready at a rising edge. m_axis_* is held stable while tvalid=1 and tready=0.
//    tvalid never depends combinationally on tready.
//  - HDR: s_axis_tready=1, m_axis_tvalid=0. Each beat shifts into hdr_buf[idx]; idx counts 0..5.
//    - tlast on beat idx<5: runt; runt_cnt++ (saturating); remain in HDR with idx=0.
//    - Beat idx=5: dst complete; latch last5=tlast, user5=tuser. Evaluate:
//      accept = promisc_i | dst==mac_addr_i | (bcast_en_i & dst==48'hFFFF_FFFF_FFFF) | (mcast_en_i & dst[40]).
//      accept -> REPLAY; else DROP, or HDR directly if last5=1. Reject with last5=1 counts dropped immediately.
//    - Config inputs are sampled only at the idx=5 beat; changes mid-frame have no effect on that frame.
//  - REPLAY: s_axis_tready=0; m_axis_tvalid=1 presenting hdr_buf[0..5] in order, one per downstream transfer.
//    - First replay byte is valid on the cycle after the idx=5 beat (1-cycle latency).
//    - On hdr_buf[5]: m_axis_tlast=last5, m_axis_tuser=user5 (0 on bytes 0..4).
//    - After hdr_buf[5] transfers: last5=1 -> accepted_cnt++, HDR; else PASS.
//  - PASS: combinational passthrough: m_axis_tdata/tvalid/tlast/tuser = s_axis_*, s_axis_tready = m_axis_tready.
//    Transfer with tlast -> accepted_cnt++ (counts regardless of tuser), HDR.
//  - DROP: s_axis_tready=1, m_axis_tvalid=0. Transfer with tlast -> dropped_cnt++, HDR.
//  - Counters: +1 per event, saturate at all-ones (no wrap). At most one counter increments per cycle.
//  - No bubbles required between frames: the byte after a tlast transfer is byte 0 of the next frame's HDR.
// TESTING
//  1. mac_addr_i=02:00:00:00:00:01, 64-byte frame to that dst, tready=1 -> 64 identical bytes out, tlast on 64th, accepted_cnt=1.
//  2. Same config, frame to 02:00:00:00:00:02 -> no m_axis_tvalid, s_axis_tready held 1 for 64 beats, dropped_cnt=1.
//  3. bcast_en_i=1: broadcast frame accepted; with bcast_en_i=0 and mcast_en_i=1 also accepted (I/G=1).
//     01:00:5E:00:00:01 accepted only when mcast_en_i=1.
//  4. 4-byte frame with tlast on byte 4 -> no output, runt_cnt=1. Exactly-6-byte matching frame -> 6 bytes out, tlast on byte 6.
//  5. Accepted frame with tuser=1 on last beat plus random m_axis_tready (50%) and s_axis_tvalid gaps
//     -> byte-exact output, tuser=1 only on tlast, no data change while stalled.
//  6. Back-to-back accept/drop/accept frames with no idle cycles -> 2 accepted, 1 dropped, order preserved.
//     Assert logic_rst_n=0 mid-PASS -> m_axis_tvalid=0 the next cycle, counters=0.

Source files
------------

// File: rtl/eth_rx_dst_mac_filter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : eth_rx_dst_mac_filter_if
//  Description : 8-bit AXI-Stream link (data, valid, ready, last, user)
//                used on both sides of the destination-MAC filter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface eth_rx_dst_mac_filter_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    // Stream source: drives the payload, observes back-pressure.
    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    // Stream sink: observes the payload, drives back-pressure.
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

`default_nettype wire

// File: rtl/eth_rx_dst_mac_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : eth_rx_dst_mac_filter
//  Description : Buffers the 6-byte destination MAC of each received frame,
//                checks it against station / broadcast / multicast /
//                promiscuous rules, replays accepted frames unchanged and
//                silently drains rejected or runt frames. Keeps saturating
//                accepted / dropped / runt counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_dst_mac_filter #(
    parameter int CNT_WIDTH = 32
) (
    input  wire                  logic_clk,
    input  wire                  logic_rst_n,
    eth_rx_dst_mac_filter_if.slave  s_axis,
    eth_rx_dst_mac_filter_if.master m_axis,
    input  wire [47:0]           mac_addr_i,
    input  wire                  promisc_i,
    input  wire                  bcast_en_i,
    input  wire                  mcast_en_i,
    output logic [CNT_WIDTH-1:0] accepted_cnt_o,
    output logic [CNT_WIDTH-1:0] dropped_cnt_o,
    output logic [CNT_WIDTH-1:0] runt_cnt_o
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_HDR    = 2'd0,
        ST_REPLAY = 2'd1,
        ST_PASS   = 2'd2,
        ST_DROP   = 2'd3
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_idx, w_idx_nxt;          // header byte being captured
    logic [2:0] r_rep, w_rep_nxt;          // header byte being replayed
    logic [7:0] r_hdr [0:5];
    logic       r_last5, r_user5;          // tlast/tuser seen on header byte 5

    logic [47:0] w_dst;
    logic        w_accept;
    logic        w_hdr_we, w_lat5;
    logic        w_inc_acc, w_inc_drop, w_inc_runt;
    logic        w_s_ready, w_m_valid, w_m_last, w_m_user;
    logic [7:0]  w_m_data;

    // The incoming byte completes the address when it is header byte 5.
    assign w_dst    = {r_hdr[0], r_hdr[1], r_hdr[2], r_hdr[3], r_hdr[4], s_axis.tdata};
    assign w_accept = promisc_i
                    | (w_dst == mac_addr_i)
                    | (bcast_en_i & (w_dst == 48'hFFFF_FFFF_FFFF))
                    | (mcast_en_i & w_dst[40]);

    // Next-state, datapath steering and counter-event decode.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_rep_nxt   = r_rep;
        w_hdr_we    = 1'b0;
        w_lat5      = 1'b0;
        w_inc_acc   = 1'b0;
        w_inc_drop  = 1'b0;
        w_inc_runt  = 1'b0;
        w_s_ready   = 1'b0;
        w_m_valid   = 1'b0;
        w_m_data    = 8'h00;
        w_m_last    = 1'b0;
        w_m_user    = 1'b0;
        case (r_state)
            ST_HDR: begin
                w_s_ready = 1'b1;
                if (s_axis.tvalid) begin
                    w_hdr_we = 1'b1;
                    if (r_idx == 3'd5) begin
                        w_lat5    = 1'b1;
                        w_idx_nxt = 3'd0;
                        if (w_accept) begin
                            w_state_nxt = ST_REPLAY;
                            w_rep_nxt   = 3'd0;
                        end else if (s_axis.tlast) begin
                            w_inc_drop = 1'b1;
                        end else begin
                            w_state_nxt = ST_DROP;
                        end
                    end else if (s_axis.tlast) begin
                        w_inc_runt = 1'b1;
                        w_idx_nxt  = 3'd0;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            ST_REPLAY: begin
                w_m_valid = 1'b1;
                w_m_data  = r_hdr[r_rep];
                if (r_rep == 3'd5) begin
                    w_m_last = r_last5;
                    w_m_user = r_user5;
                end
                if (m_axis.tready) begin
                    if (r_rep == 3'd5) begin
                        if (r_last5) begin
                            w_inc_acc   = 1'b1;
                            w_state_nxt = ST_HDR;
                        end else begin
                            w_state_nxt = ST_PASS;
                        end
                    end else begin
                        w_rep_nxt = r_rep + 3'd1;
                    end
                end
            end
            ST_PASS: begin
                w_s_ready = m_axis.tready;
                w_m_valid = s_axis.tvalid;
                w_m_data  = s_axis.tdata;
                w_m_last  = s_axis.tlast;
                w_m_user  = s_axis.tuser;
                if (s_axis.tvalid && m_axis.tready && s_axis.tlast) begin
                    w_inc_acc   = 1'b1;
                    w_state_nxt = ST_HDR;
                end
            end
            default: begin  // ST_DROP
                w_s_ready = 1'b1;
                if (s_axis.tvalid && s_axis.tlast) begin
                    w_inc_drop  = 1'b1;
                    w_state_nxt = ST_HDR;
                end
            end
        endcase
    end

    // Both handshake outputs are forced low while reset is held.
    assign s_axis.tready = w_s_ready & logic_rst_n;
    assign m_axis.tvalid = w_m_valid & logic_rst_n;
    assign m_axis.tdata  = w_m_data;
    assign m_axis.tlast  = w_m_last;
    assign m_axis.tuser  = w_m_user;

    // State register plus the end-of-header flags.
    always_ff @(posedge logic_clk) begin
        if (!logic_rst_n) begin
            r_state <= ST_HDR;
            r_idx   <= 3'd0;
            r_rep   <= 3'd0;
            r_last5 <= 1'b0;
            r_user5 <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_rep   <= w_rep_nxt;
            if (w_lat5) begin
                r_last5 <= s_axis.tlast;
                r_user5 <= s_axis.tuser;
            end
        end
    end

    // Header byte capture; contents are don't-care until written.
    always_ff @(posedge logic_clk) begin
        if (w_hdr_we && logic_rst_n) begin
            r_hdr[r_idx] <= s_axis.tdata;
        end
    end

    // Saturating frame counters; the FSM raises at most one event per cycle.
    always_ff @(posedge logic_clk) begin
        if (!logic_rst_n) begin
            accepted_cnt_o <= '0;
            dropped_cnt_o  <= '0;
            runt_cnt_o     <= '0;
        end else begin
            if (w_inc_acc && !(&accepted_cnt_o)) accepted_cnt_o <= accepted_cnt_o + c_CNT_ONE;
            if (w_inc_drop && !(&dropped_cnt_o)) dropped_cnt_o  <= dropped_cnt_o + c_CNT_ONE;
            if (w_inc_runt && !(&runt_cnt_o))    runt_cnt_o     <= runt_cnt_o + c_CNT_ONE;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_eth_rx_dst_mac_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_eth_rx_dst_mac_filter
//  Description : Self-checking bench for eth_rx_dst_mac_filter. A frame-level
//                reference model predicts the output byte stream and the
//                counters; a monitor compares every downstream transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_rx_dst_mac_filter;

    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;
    localparam logic [47:0] c_STATION = 48'h02_00_00_00_00_01;

    typedef logic [7:0] byte_q_t [$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [47:0] mac_addr = c_STATION;
    logic promisc = 1'b0, bcast_en = 1'b0, mcast_en = 1'b0;
    logic [CNT_W-1:0] acc_cnt, drop_cnt, runt_cnt;

    eth_rx_dst_mac_filter_if s_if ();
    eth_rx_dst_mac_filter_if m_if ();

    eth_rx_dst_mac_filter #(.CNT_WIDTH(CNT_W)) dut (
        .logic_clk      (clk),
        .logic_rst_n    (rst_n),
        .s_axis         (s_if),
        .m_axis         (m_if),
        .mac_addr_i     (mac_addr),
        .promisc_i      (promisc),
        .bcast_en_i     (bcast_en),
        .mcast_en_i     (mcast_en),
        .accepted_cnt_o (acc_cnt),
        .dropped_cnt_o  (drop_cnt),
        .runt_cnt_o     (runt_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    logic [9:0] exp_q [$];          // {tuser, tlast, tdata}
    int m_acc = 0, m_drop = 0, m_runt = 0;
    bit tready_rand = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    function automatic byte_q_t make_frame(input logic [47:0] dst, input int len);
        byte_q_t q;
        for (int i = 0; i < len; i++) begin
            if (i < 6) q.push_back(dst[47 - 8*i -: 8]);
            else       q.push_back(8'($urandom));
        end
        return q;
    endfunction

    // Frame-level reference: decide the frame's fate from its first six bytes
    // and the configuration in force when it starts.
    task automatic model_frame(input byte_q_t d, input bit user);
        logic [47:0] dst;
        bit acc;
        if (d.size() < 6) begin
            m_runt = sat_inc(m_runt);
            return;
        end
        dst = {d[0], d[1], d[2], d[3], d[4], d[5]};
        acc = promisc || (dst == mac_addr) || (bcast_en && dst == 48'hFFFF_FFFF_FFFF)
              || (mcast_en && d[0][0]);
        if (acc) begin
            for (int i = 0; i < d.size(); i++) begin
                bit last = (i == d.size() - 1);
                exp_q.push_back({user & last, last, d[i]});
            end
            m_acc = sat_inc(m_acc);
        end else begin
            m_drop = sat_inc(m_drop);
        end
    endtask

    // Drives one frame; must be entered on a falling edge and returns on one.
    task automatic send_frame(input byte_q_t d, input bit user, input bit gaps,
                              input int stop_at, input bit scramble, output int cycles);
        int budget;
        cycles = 0;
        for (int i = 0; i < d.size(); i++) begin
            if (i == stop_at) begin
                s_if.tvalid = 1'b0;
                return;
            end
            while (gaps && $urandom_range(0, 3) == 0) begin
                s_if.tvalid = 1'b0;
                @(negedge clk);
                cycles++;
            end
            s_if.tdata  = d[i];
            s_if.tlast  = (i == d.size() - 1);
            s_if.tuser  = (i == d.size() - 1) ? user : 1'b0;
            s_if.tvalid = 1'b1;
            budget = 0;
            #2;
            while (!s_if.tready) begin
                @(negedge clk);
                cycles++;
                budget++;
                if (budget > 2000) begin
                    check("handshake_timeout", 64'(budget), 64'd0);
                    s_if.tvalid = 1'b0;
                    return;
                end
                #2;
            end
            @(negedge clk);
            cycles++;
            if (scramble && i == 5) begin
                promisc  = 1'b0;
                bcast_en = 1'b0;
                mcast_en = 1'b0;
                mac_addr = {$urandom, $urandom} & 48'hFEFF_FFFF_FFFF;
            end
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
    endtask

    task automatic run_frame(input byte_q_t d, input bit user, input bit gaps, output int cycles);
        model_frame(d, user);
        send_frame(d, user, gaps, -1, 1'b0, cycles);
    endtask

    task automatic drain_and_check(input string tag);
        int budget = 0;
        while (exp_q.size() != 0 && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_acc"},  64'(acc_cnt),  64'(m_acc));
        check({tag, "_drop"}, 64'(drop_cnt), 64'(m_drop));
        check({tag, "_runt"}, 64'(runt_cnt), 64'(m_runt));
    endtask

    // Downstream monitor: randomises ready, compares each transfer, checks
    // that a stalled beat is held unchanged.
    initial begin
        logic [9:0] cur, prev;
        bit prev_stall;
        prev_stall = 1'b0;
        prev = '0;
        m_if.tready = 1'b0;
        forever begin
            @(negedge clk);
            m_if.tready = tready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            #2;
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            cur = {m_if.tuser, m_if.tlast, m_if.tdata};
            if (prev_stall) check("stall_hold", {m_if.tvalid, cur}, {1'b1, prev});
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) check("unexpected_out", {1'b1, cur}, 64'd0);
                else                   check("out_byte", 64'(cur), 64'(exp_q.pop_front()));
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev = cur;
        end
    end

    initial begin
        byte_q_t f, rem;
        int cyc;
        logic [47:0] dst;
        s_if.tvalid = 1'b0; s_if.tdata = 8'h00; s_if.tlast = 1'b0; s_if.tuser = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #2;
        check("rst_s_ready", 64'(s_if.tready), 64'd0);
        check("rst_m_valid", 64'(m_if.tvalid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        check("hdr_s_ready", 64'(s_if.tready), 64'd1);
        check("rst_counters", {acc_cnt, drop_cnt, runt_cnt}, 64'd0);
        @(negedge clk);

        // Station match, 64 bytes, no stalls: 6 header + 6 replay + 58 pass cycles
        run_frame(make_frame(c_STATION, 64), 1'b0, 1'b0, cyc);
        check("accept_cycles", 64'(cyc), 64'd70);
        drain_and_check("t1");

        // Non-matching station: drained at one beat per cycle
        run_frame(make_frame(48'h02_00_00_00_00_02, 64), 1'b0, 1'b0, cyc);
        check("drop_cycles", 64'(cyc), 64'd64);
        drain_and_check("t2");

        // Broadcast / multicast rules
        bcast_en = 1'b1;
        run_frame(make_frame(48'hFFFF_FFFF_FFFF, 20), 1'b0, 1'b0, cyc);
        bcast_en = 1'b0; mcast_en = 1'b1;
        run_frame(make_frame(48'hFFFF_FFFF_FFFF, 20), 1'b0, 1'b0, cyc);
        run_frame(make_frame(48'h01_00_5E_00_00_01, 16), 1'b0, 1'b0, cyc);
        mcast_en = 1'b0;
        run_frame(make_frame(48'h01_00_5E_00_00_01, 16), 1'b0, 1'b0, cyc);
        run_frame(make_frame(48'hFFFF_FFFF_FFFF, 16), 1'b0, 1'b0, cyc);
        drain_and_check("t3");

        // Runt and exactly-six-byte frames
        run_frame(make_frame(c_STATION, 4), 1'b0, 1'b0, cyc);
        run_frame(make_frame(c_STATION, 6), 1'b1, 1'b0, cyc);
        run_frame(make_frame(48'h02_00_00_00_00_07, 6), 1'b0, 1'b0, cyc);
        drain_and_check("t4");

        // Stalls on both sides, tuser on the last beat
        tready_rand = 1'b1;
        run_frame(make_frame(c_STATION, 30), 1'b1, 1'b1, cyc);
        run_frame(make_frame(c_STATION, 7), 1'b1, 1'b1, cyc);
        drain_and_check("t5");

        // Back-to-back accept / drop / accept, no idle cycles
        tready_rand = 1'b0;
        run_frame(make_frame(c_STATION, 12), 1'b0, 1'b0, cyc);
        run_frame(make_frame(48'h0A_0B_0C_0D_0E_0F, 9), 1'b0, 1'b0, cyc);
        run_frame(make_frame(c_STATION, 10), 1'b1, 1'b0, cyc);
        drain_and_check("t6");

        // Runt counter saturation
        for (int i = 0; i < 18; i++) run_frame(make_frame(c_STATION, $urandom_range(1, 5)), 1'b0, 1'b0, cyc);
        drain_and_check("sat");

        // Randomised frames; half change configuration after the header
        tready_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: dst = c_STATION;
                1: dst = c_STATION ^ 48'h1;
                2: dst = 48'hFFFF_FFFF_FFFF;
                3: dst = {8'h01, 8'($urandom), $urandom};
                default: dst = {$urandom, $urandom};
            endcase
            mac_addr = c_STATION;
            promisc  = ($urandom_range(0, 3) == 0);
            bcast_en = 1'($urandom);
            mcast_en = 1'($urandom);
            f = make_frame(dst, $urandom_range(1, 40));
            model_frame(f, 1'($urandom));
            send_frame(f, exp_q.size() != 0 ? exp_q[exp_q.size()-1][9] : 1'b0,
                       1'($urandom), -1, 1'($urandom), cyc);
        end
        drain_and_check("rand");

        // Reset in the middle of a passthrough frame
        tready_rand = 1'b0;
        mac_addr = c_STATION; promisc = 1'b0; bcast_en = 1'b0; mcast_en = 1'b0;
        f = make_frame(c_STATION, 64);
        model_frame(f, 1'b0);
        send_frame(f, 1'b0, 1'b0, 20, 1'b0, cyc);
        rst_n = 1'b0;
        @(negedge clk);
        #2;
        check("midrst_m_valid", 64'(m_if.tvalid), 64'd0);
        check("midrst_counters", {acc_cnt, drop_cnt, runt_cnt}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        m_acc = 0; m_drop = 0; m_runt = 0;
        rem.delete();
        for (int i = 20; i < 64; i++) rem.push_back(f[i]);
        run_frame(rem, 1'b0, 1'b0, cyc);
        run_frame(make_frame(c_STATION, 8), 1'b0, 1'b0, cyc);
        drain_and_check("post_rst");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    // Absolute watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
